pb_event_fsm: RTL and testbench

//  Classifies a debounced, active-high push-button level into one-cycle event pulses.

---
 rtl/pb_event_if.sv | 31 +++
 rtl/pb_event_fsm.sv | 108 ++++++++++
 tb/tb_pb_event_fsm.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pb_event_if.sv
// Push-button event bundle: debounced level in, event pulses out.
// master drives the button level, slave (the classifier) drives events.
interface pb_event_if;
  logic pb_debounced;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic repeat_pulse;
  logic pb_held;

  modport master (
    output pb_debounced,
    input  press_pulse,
    input  release_pulse,
    input  short_press,
    input  long_press,
    input  repeat_pulse,
    input  pb_held
  );

  modport slave (
    input  pb_debounced,
    output press_pulse,
    output release_pulse,
    output short_press,
    output long_press,
    output repeat_pulse,
    output pb_held
  );
endinterface

// File: rtl/pb_event_fsm.sv
// Push-button event classifier: press/release/short/long/repeat pulses.
// Auto-repeat is built only when PB_AUTO_REPEAT_EN is defined.
module pb_event_fsm #(
  parameter int CNT_W        = 8,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  pb_event_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LongC = CNT_W'(LONG_TICKS);

  state_e           state_q;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_d;
  logic             press_q;
  logic             rel_q;
  logic             short_q;
  logic             long_q;
  logic             rpt_q;
  logic             held_q;

  // Saturating increment keeps long/repeat from re-firing on wrap
  assign hold_d = (&hold_q) ? hold_q : hold_q + 1'b1;

`ifdef PB_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RptLastC = CNT_W'(REPEAT_TICKS - 1);
  logic [CNT_W-1:0] rcnt_q;
`else
  localparam int UnusedRptTicks = REPEAT_TICKS;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
`ifdef PB_AUTO_REPEAT_EN
      rcnt_q  <= '0;
`endif
    end else begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      if (!bus.pb_debounced) begin
        state_q <= IDLE;
        hold_q  <= '0;
        held_q  <= 1'b0;
        if (state_q != IDLE) begin
          rel_q   <= 1'b1;
          short_q <= (state_q == PRESSED);
        end
      end else begin
        hold_q <= hold_d;
        held_q <= 1'b1;
        unique case (state_q)
          IDLE: begin
            state_q <= PRESSED;
            press_q <= 1'b1;
          end
          PRESSED: begin
            if (hold_d == LongC) begin
              state_q <= LONG_HELD;
              long_q  <= 1'b1;
`ifdef PB_AUTO_REPEAT_EN
              rcnt_q  <= '0;
`endif
            end
          end
          LONG_HELD: begin
`ifdef PB_AUTO_REPEAT_EN
            if (rcnt_q == RptLastC) begin
              rcnt_q <= '0;
              rpt_q  <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.short_press   = short_q;
  assign bus.long_press    = long_q;
  assign bus.repeat_pulse  = rpt_q;
  assign bus.pb_held       = held_q;

endmodule

// File: tb/tb_pb_event_fsm.sv
// Bench for pb_event_fsm: hold-count reference model feeds a scoreboard.
// Expected repeat pulses follow PB_AUTO_REPEAT_EN when defined.
module tb_pb_event_fsm;

  localparam int LT = 8;
  localparam int RT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pb_event_if ifc ();

  pb_event_fsm #(
    .CNT_W        (8),
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int h = 0;
  int nlong = 0;
  logic [5:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {ifc.press_pulse, ifc.release_pulse, ifc.short_press,
            ifc.long_press, ifc.repeat_pulse, ifc.pb_held};
  endfunction

  // {press, release, short, long, repeat, held}
  task automatic step(input logic pb);
    logic [5:0] e;
    logic [5:0] got;
    int hn;
    ifc.pb_debounced = pb;
    e = '0;
    if (pb) begin
      hn   = h + 1;
      e[5] = (h == 0);
      e[2] = (hn == LT);
`ifdef PB_AUTO_REPEAT_EN
      e[1] = (hn > LT) && (((hn - LT) % RT) == 0);
`endif
      e[0] = 1'b1;
    end else begin
      hn   = 0;
      e[4] = (h > 0);
      e[3] = (h > 0) && (h < LT);
    end
    h = hn;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = outs();
    if (exp_q.size() == 0) chk("sb_empty", 0, 1);
    else chk("evt", 32'(got), 32'(exp_q.pop_front()));
    chk("excl", ($countones({got[5], got[2], got[1]}) <= 1) ? 1 : 0, 1);
    if (got[2]) nlong++;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
    step(1'b0);
  endtask

  initial begin
    ifc.pb_debounced = 1'b0;
    #3;
    chk("rst_outs", 32'(outs()), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    step(1'b0);
    step(1'b0);
    hold(3);
    step(1'b0);
    hold(7);
    step(1'b0);
    hold(8);
    step(1'b0);
    hold(20);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);

    for (int i = 0; i < 5; i++) step(1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 32'(outs()), 0);
    h = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold", 32'(outs()), 0);
    end
    rst_n = 1'b1;
    nlong = 0;
    hold(9);
    chk("rst_long", nlong, 1);
    step(1'b0);

    nlong = 0;
    hold(300);
    chk("sat_long", nlong, 1);
    step(1'b0);

    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)));
    step(1'b0);

    chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end

endmodule
